uart_sender: RTL and testbench
==============================

UART_SENDER -- requirements
Module: uart_sender

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 5208, meaning clk cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port TX_DATA  input  8  byte to transmit; sampled only on an accept cycle.
REQ-005 SHALL have port TX_EN  input  1  transmit request, level-sensitive, one cycle sufficient.
REQ-006 SHALL have port TX_STATUS  output  1  1 = idle and able to accept, 0 = frame in progress.
REQ-007 SHALL have port UART_TX  output  1  serial line, idle-high, 8N1 framing.
REQ-008 SHALL have port TX_DONE  output  1  single-cycle pulse marking frame completion.

Function
REQ-009 SHALL be a registered design: UART_TX, TX_STATUS and TX_DONE driven directly from flops, no combinational path from inputs.
REQ-010 SHALL implement states IDLE, START, DATA, STOP.
REQ-011 Accept cycle SHALL be any rising edge with TX_EN=1 and TX_STATUS=1 (state IDLE); on it, TX_DATA latched into an 8-bit shift register, state -> START, bit counter cleared, baud counter cleared.
REQ-012 TX_EN while TX_STATUS=0 SHALL be ignored; no queuing, latched byte unaffected by TX_DATA changes.
REQ-013 Baud counter SHALL count 0..BAUD_DIV-1 and wrap; each state holds for exactly BAUD_DIV cycles per bit.
REQ-014 START SHALL drive UART_TX=0 for BAUD_DIV cycles, then -> DATA.
REQ-015 DATA SHALL drive 8 bits LSB first, each BAUD_DIV cycles; 3-bit bit index increments at each baud wrap; after bit 7 wrap -> STOP.
REQ-016 STOP SHALL drive UART_TX=1 for BAUD_DIV cycles, then -> IDLE.
REQ-017 With accept at edge k, UART_TX SHALL carry the frame in cycles k+1 .. k+10*BAUD_DIV, and TX_STATUS SHALL be 0 for exactly those cycles.
REQ-018 TX_STATUS SHALL return to 1 in cycle k+10*BAUD_DIV+1; TX_DONE SHALL be 1 in that same cycle only.
REQ-019 An accept on the edge where TX_STATUS returns to 1 SHALL be honoured, giving back-to-back frames with no extra idle bit beyond the stop bit.
REQ-020 In IDLE, UART_TX SHALL be 1 and counters SHALL hold at 0.
REQ-021 Illegal/unreachable state encodings SHALL return to IDLE on the next edge with UART_TX=1.

Reset
REQ-022 On reset=1 at an edge: state IDLE, UART_TX=1, TX_STATUS=1, TX_DONE=0, shift register 0, both counters 0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no TX_DONE pulse; UART_TX=1 from the following cycle.
REQ-024 reset SHALL take priority over a simultaneous TX_EN; no byte accepted on a reset edge.
REQ-025 First accept possible on the first edge after reset deasserts.

Verification (BAUD_DIV=4 unless noted)
REQ-026 After reset, TX_EN=1, TX_DATA=8'hA5 at edge k -> UART_TX = 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each held 4 cycles over k+1..k+40; TX_STATUS=0 over same window; TX_DONE=1 only in cycle k+41.
REQ-027 Accept 8'h3C, then TX_EN=1 with TX_DATA=8'hFF at cycle k+20 -> serial frame still 8'h3C; no second frame starts; TX_STATUS stays 0 until k+41.
REQ-028 Hold TX_EN=1 continuously with 8'h01 then 8'h80 presented -> two frames back to back: second start bit begins cycle k+42; line never idles between stop bit and next start bit.
REQ-029 Assert reset at cycle k+15 of a frame for 8'h55 -> UART_TX=1, TX_STATUS=1 from next cycle; no TX_DONE pulse; subsequent 8'h0F transmits cleanly.
REQ-030 reset=1 and TX_EN=1 on same edge -> no frame; UART_TX stays 1 for 50 cycles.
REQ-031 BAUD_DIV=2, byte 8'h00 -> frame occupies exactly 20 cycles, UART_TX low for 18 cycles then high for 2; TX_DONE in cycle k+21.

Source files
------------

// File: rtl/uart_sender.sv
// rtl/uart_sender.sv - 8N1 UART transmitter, one byte per request, registered outputs
// Frame occupies 10*BAUD_DIV cycles after the accept edge; TX_DONE pulses on the first idle cycle.
module uart_sender #(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] TX_DATA,
    input  logic       TX_EN,
    output logic       TX_STATUS,
    output logic       UART_TX,
    output logic       TX_DONE
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        status_q, status_d;
    logic        done_q, done_d;
    logic        baud_wrap;

    assign baud_wrap = (baud_q == BAUD_LAST);
    assign UART_TX   = tx_q;
    assign TX_STATUS = status_q;
    assign TX_DONE   = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= 16'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            status_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            status_q <= status_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (TX_EN) state_d = START;
            START:   if (baud_wrap) state_d = DATA;
            DATA:    if (baud_wrap && bit_q == 3'd7) state_d = STOP;
            STOP:    if (baud_wrap) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output flops are loaded with the value for the cycle that follows the edge,
    // so every serial bit appears exactly one edge after the decision that selects it.
    always_comb begin
        baud_d   = 16'd0;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = 1'b1;
        status_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                bit_d    = 3'd0;
                status_d = 1'b1;
                if (TX_EN) begin
                    shift_d  = TX_DATA;
                    tx_d     = 1'b0;
                    status_d = 1'b0;
                end
            end
            START: begin
                baud_d = baud_wrap ? 16'd0 : baud_q + 16'd1;
                tx_d   = baud_wrap ? shift_q[0] : 1'b0;
            end
            DATA: begin
                baud_d = baud_wrap ? 16'd0 : baud_q + 16'd1;
                tx_d   = shift_q[0];
                if (baud_wrap) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP: begin
                baud_d = baud_wrap ? 16'd0 : baud_q + 16'd1;
                if (baud_wrap) begin
                    status_d = 1'b1;
                    done_d   = 1'b1;
                end
            end
            default: begin
                bit_d    = 3'd0;
                status_d = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_sender.sv
// tb/tb_uart_sender.sv - scoreboard bench for uart_sender
module tb_uart_sender;
    localparam int B     = 4;
    localparam int FRAME = 10 * B;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'd0;
    logic       tx_en = 1'b0;
    logic       tx_status, uart_tx, tx_done;
    logic [7:0] tx_data2 = 8'd0;
    logic       tx_en2 = 1'b0;
    logic       tx_status2, uart_tx2, tx_done2;

    uart_sender #(.BAUD_DIV(B)) dut (
        .clk(clk), .reset(reset), .TX_DATA(tx_data), .TX_EN(tx_en),
        .TX_STATUS(tx_status), .UART_TX(uart_tx), .TX_DONE(tx_done)
    );

    uart_sender #(.BAUD_DIV(2)) dut2 (
        .clk(clk), .reset(reset), .TX_DATA(tx_data2), .TX_EN(tx_en2),
        .TX_STATUS(tx_status2), .UART_TX(uart_tx2), .TX_DONE(tx_done2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         at_edge;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       ent;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         free_edge = 0;
    bit         started = 1'b0;
    bit         rst_at_edge = 1'b0;
    bit         mon_active = 1'b0;
    bit         done_next = 1'b0;
    int         j = 0;
    logic [7:0] cur_byte = 8'd0;
    logic [7:0] rx_byte = 8'd0;
    logic [9:0] frame = 10'd0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0d want %0d", name, cyc, act, req);
        end
    endtask

    // Reference: a byte is accepted whenever TX_EN is high and the sender has been
    // free since the previous frame's 10 bit times plus the completion cycle.
    always @(posedge clk) begin
        cyc++;
        rst_at_edge = reset;
        if (reset) begin
            started   = 1'b1;
            free_edge = cyc + 1;
        end else if (started && tx_en && cyc >= free_edge) begin
            exp_q.push_back('{data: tx_data, at_edge: cyc});
            free_edge = cyc + FRAME + 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            if (rst_at_edge) begin
                chk("reset_line", int'(uart_tx), 1);
                chk("reset_status", int'(tx_status), 1);
                chk("reset_done", int'(tx_done), 0);
                mon_active = 1'b0;
                done_next  = 1'b0;
            end else begin
                if (!mon_active && exp_q.size() > 0 && exp_q[0].at_edge < cyc) begin
                    chk("start_late", cyc, exp_q[0].at_edge);
                    exp_q.delete(0);
                end
                if (!mon_active && exp_q.size() > 0 && uart_tx == 1'b0) begin
                    ent = exp_q.pop_front();
                    chk("start_edge", cyc, ent.at_edge);
                    cur_byte   = ent.data;
                    frame      = {1'b1, ent.data, 1'b0};
                    rx_byte    = 8'd0;
                    mon_active = 1'b1;
                    j          = 0;
                end
                if (mon_active) begin
                    chk("line", int'(uart_tx), int'(frame[j / B]));
                    chk("status_busy", int'(tx_status), 0);
                    chk("done_busy", int'(tx_done), 0);
                    if (j / B >= 1 && j / B <= 8 && j % B == B / 2)
                        rx_byte[j / B - 1] = uart_tx;
                    j++;
                    if (j == FRAME) begin
                        chk("byte", int'(rx_byte), int'(cur_byte));
                        mon_active = 1'b0;
                        done_next  = 1'b1;
                    end
                end else begin
                    chk("idle_line", int'(uart_tx), 1);
                    chk("idle_status", int'(tx_status), 1);
                    chk("done_pulse", int'(tx_done), int'(done_next));
                    done_next = 1'b0;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d);
        tx_data = d;
        tx_en   = 1'b1;
        @(negedge clk);
        tx_en   = 1'b0;
        tx_data = 8'($urandom);
    endtask

    initial begin
        int n;
        // reset held with a request pending: nothing may be accepted
        reset   = 1'b1;
        tx_en   = 1'b1;
        tx_data = 8'h5A;
        idle(3);
        reset = 1'b0;
        tx_en = 1'b0;
        idle(50);

        send(8'hA5);
        idle(45);

        send(8'h3C);
        idle(19);
        tx_data = 8'hFF;
        tx_en   = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        idle(30);

        tx_data = 8'h01;
        tx_en   = 1'b1;
        @(negedge clk);
        tx_data = 8'h80;
        idle(44);
        tx_en = 1'b0;
        idle(45);

        send(8'h55);
        idle(14);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        send(8'h0F);
        idle(45);

        for (int i = 0; i < 40; i++) begin
            idle($urandom_range(0, 45));
            n = $urandom_range(1, 3);
            for (int m = 0; m < n; m++) begin
                tx_data = 8'($urandom);
                tx_en   = 1'b1;
                @(negedge clk);
            end
            tx_en = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                idle($urandom_range(0, 30));
                reset = 1'b1;
                tx_en = 1'($urandom_range(0, 1));
                @(negedge clk);
                reset = 1'b0;
                tx_en = 1'b0;
            end
        end

        for (int w = 0; w < 200 && (exp_q.size() != 0 || mon_active); w++)
            @(negedge clk);
        chk("drain", exp_q.size() + int'(mon_active), 0);
        idle(2);

        chk("b2_idle", int'(uart_tx2), 1);
        tx_data2 = 8'h00;
        tx_en2   = 1'b1;
        @(negedge clk);
        tx_en2 = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            chk("b2_line", int'(uart_tx2), (c <= 18) ? 0 : 1);
            chk("b2_status", int'(tx_status2), (c <= 20) ? 0 : 1);
            chk("b2_done", int'(tx_done2), (c == 21) ? 1 : 0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
